// File: rtl/muldiv_pkg.sv
// Shared CPU defines for the iterative multiply/divide unit:
// M-extension funct3 codes, FSM state encodings and operand signedness decode.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide, on a {high, low} accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               divide,
    output logic [2*WIDTH-1:0] next_acc
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum         = '0;
        shifted_rem = '0;
        diff        = '0;
        next_acc    = '0;
        if (divide) begin
            // low word holds the remaining dividend bits, quotient bits enter at bit 0
            shifted_rem = acc[2*WIDTH-1:WIDTH-1];
            diff        = shifted_rem - {1'b0, operand};
            if (!diff[WIDTH])
                next_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                next_acc = {shifted_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
            next_acc = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative 32-bit M-extension multiply/divide with fixed 35-cycle latency,
// returning its result through a register-file write port.
//
// state | meaning
// IDLE  | waiting for start, captures request
// PREP  | record operand signs, form magnitudes
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction, divide-by-zero, result select
// DONE  | one-cycle write strobe
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2:0]                operation,
    input  logic [WIDTH-1:0]          operand_a,
    input  logic [WIDTH-1:0]          operand_b,
    input  logic [REG_ADDR_WIDTH-1:0] destination,
    output logic                      busy,
    output logic                      write_enable,
    output logic [REG_ADDR_WIDTH-1:0] address_write,
    output logic [WIDTH-1:0]          write_data
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t                    state;
    logic [CNT_W-1:0]          count;
    logic [2:0]                op_q;
    logic [WIDTH-1:0]          a_q;
    logic [WIDTH-1:0]          b_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [WIDTH-1:0]          step_operand;
    logic [2*WIDTH-1:0]        acc;
    logic                      sign_a;
    logic                      sign_b;

    logic                      neg_a;
    logic                      neg_b;
    logic [WIDTH-1:0]          mag_a;
    logic [WIDTH-1:0]          mag_b;
    logic [2*WIDTH-1:0]        next_acc;
    logic [2*WIDTH-1:0]        product;
    logic [WIDTH-1:0]          quotient;
    logic [WIDTH-1:0]          remainder;
    logic [WIDTH-1:0]          result;

    assign busy = (state != ST_IDLE);

    assign neg_a = is_signed_a(op_q) && a_q[WIDTH-1];
    assign neg_b = is_signed_b(op_q) && b_q[WIDTH-1];
    assign mag_a = neg_a ? -a_q : a_q;
    assign mag_b = neg_b ? -b_q : b_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (step_operand),
        .divide   (op_q[2]),
        .next_acc (next_acc)
    );

    // Overflow (most-negative / -1) wraps naturally through the magnitude path.
    always_comb begin
        product   = (sign_a ^ sign_b) ? -acc : acc;
        quotient  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remainder = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        result    = '0;
        case (op_q)
            OP_MUL:                        result = product[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = product[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               result = (b_q == '0) ? '1 : quotient;
            default:                       result = (b_q == '0) ? a_q : remainder;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rd_q          <= '0;
            step_operand  <= '0;
            acc           <= '0;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            write_enable  <= 1'b0;
            address_write <= '0;
            write_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    write_enable <= 1'b0;
                    if (start) begin
                        op_q  <= operation;
                        a_q   <= operand_a;
                        b_q   <= operand_b;
                        rd_q  <= destination;
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    sign_a <= neg_a;
                    sign_b <= neg_b;
                    count  <= '0;
                    if (op_q[2]) begin
                        acc          <= {{WIDTH{1'b0}}, mag_a};
                        step_operand <= mag_b;
                    end else begin
                        acc          <= {{WIDTH{1'b0}}, mag_b};
                        step_operand <= mag_a;
                    end
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    acc   <= next_acc;
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    write_data    <= result;
                    address_write <= rd_q;
                    write_enable  <= (rd_q != '0);
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    write_enable <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    write_enable <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
